// File: rtl/prog_loader_pkg.sv
`default_nettype none
// prog_loader_pkg: loader state encoding, sizing constants and length check.
// Rev 1.0
package prog_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_HI   = 3'd1,
        LD_LO   = 3'd2,
        LD_CSUM = 3'd3,
        LD_RUN  = 3'd4,
        LD_ERR  = 3'd5
    } ld_state_t;

    localparam int PM_DEPTH   = 32;
    localparam int LD_MAX_LEN = 32;
    localparam int LEN_W      = 6;

    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (int'(len) <= LD_MAX_LEN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_ld_csum.sv
`default_nettype none
// ld_csum: 8-bit wrapping additive checksum with clear, add-enable and compare.
// Rev 1.0
module ld_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] data,
    input  logic [7:0] cmp,
    output logic       match
);

    logic [7:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

    assign match = (sum == cmp);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// prog_loader: assembles a byte stream into program-memory words, verifies the
// checksum and releases the CPU only after a verified load. Rev 1.0
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [5:0]        i_len,
    input  logic              i_valid,
    input  logic [7:0]        i_byte,
    output logic              o_ready,
    output logic              o_pm_we,
    output logic [ADDR_W-1:0] o_pm_addr,
    output logic [WORD_W-1:0] o_pm_data,
    output logic              o_cpu_rst,
    output logic              o_cpu_ce,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [LEN_W-1:0]  len_q;
    logic [7:0]        hi_q;

    logic              loading;
    logic              byte_in;
    logic              start_ok;
    logic              last_word;
    logic              csum_match;
    logic              wr;
    logic              csum_add;
    logic              csum_hit;

    assign loading   = (state == LD_HI) || (state == LD_LO) || (state == LD_CSUM);
    assign byte_in   = i_valid && loading;
    assign start_ok  = len_ok(i_len);
    assign last_word = (LEN_W'(cnt) == (len_q - LEN_W'(1)));

    // A concurrent start discards the byte: no write, no sum update, no done.
    assign wr       = !i_start && byte_in && (state == LD_LO);
    assign csum_add = !i_start && byte_in && ((state == LD_HI) || (state == LD_LO));
    assign csum_hit = !i_start && byte_in && (state == LD_CSUM) && csum_match;

    ld_csum u_csum (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clr    (i_start && start_ok),
        .add_en (csum_add),
        .data   (i_byte),
        .cmp    (i_byte),
        .match  (csum_match)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_start) begin
            state_nxt = start_ok ? LD_HI : LD_ERR;
        end else begin
            case (state)
                LD_HI:   if (byte_in) state_nxt = LD_LO;
                LD_LO:   if (byte_in) state_nxt = last_word ? LD_CSUM : LD_HI;
                LD_CSUM: if (byte_in) state_nxt = csum_match ? LD_RUN : LD_ERR;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt   <= '0;
            len_q <= '0;
            hi_q  <= 8'h00;
        end else if (i_start) begin
            if (start_ok) begin
                cnt   <= '0;
                len_q <= i_len;
            end
        end else if (byte_in) begin
            if (state == LD_HI) begin
                hi_q <= i_byte;
            end
            // Counter stops on the last word so it can never wrap past 31.
            if ((state == LD_LO) && !last_word) begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ready   <= 1'b0;
            o_busy    <= 1'b0;
            o_cpu_rst <= 1'b1;
            o_cpu_ce  <= 1'b0;
            o_err     <= 1'b0;
            o_done    <= 1'b0;
            o_pm_we   <= 1'b0;
            o_pm_addr <= '0;
            o_pm_data <= '0;
        end else begin
            o_ready   <= (state_nxt == LD_HI) || (state_nxt == LD_LO) || (state_nxt == LD_CSUM);
            o_busy    <= (state_nxt == LD_HI) || (state_nxt == LD_LO) || (state_nxt == LD_CSUM);
            o_cpu_rst <= (state_nxt != LD_RUN);
            o_cpu_ce  <= (state_nxt == LD_RUN);
            o_err     <= (state_nxt == LD_ERR);
            o_done    <= csum_hit;
            o_pm_we   <= wr;
            if (wr) begin
                o_pm_addr <= cnt;
                o_pm_data <= WORD_W'({hi_q, i_byte});
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// tb_prog_loader: table-driven loads plus hand-written corner sequences; writes
// are checked against a scoreboard queue filled as stimulus is driven.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  len;
    logic        valid;
    logic [7:0]  byte_d;
    logic        ready;
    logic        pm_we;
    logic [4:0]  pm_addr;
    logic [15:0] pm_data;
    logic        cpu_rst;
    logic        cpu_ce;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_q[$];
    logic [20:0] last_wr;
    logic        prev_we = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(5), .WORD_W(16)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_len     (len),
        .i_valid   (valid),
        .i_byte    (byte_d),
        .o_ready   (ready),
        .o_pm_we   (pm_we),
        .o_pm_addr (pm_addr),
        .o_pm_data (pm_data),
        .o_cpu_rst (cpu_rst),
        .o_cpu_ce  (cpu_ce),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pm_we === 1'b1) begin
                check("we_single_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {11'd0, pm_addr, pm_data}, 32'hFFFF_FFFF);
                end else begin
                    check("pm_write", {11'd0, pm_addr, pm_data}, {11'd0, exp_q.pop_front()});
                end
                last_wr = {pm_addr, pm_data};
            end
            prev_we = pm_we;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] l);
        start = 1'b1;
        len   = l;
        valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit stall);
        int t;
        if (stall && ($urandom_range(0, 2) == 0)) begin
            valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        valid  = 1'b1;
        byte_d = b;
        t = 0;
        while (!ready && t < 50) begin
            tick();
            t++;
        end
        if (!ready) begin
            check("ready_timeout", {31'd0, ready}, 32'd1);
        end else begin
            tick();
        end
        valid = 1'b0;
    endtask

    // Word k = {base+k, ~(base+k)}; returns nothing, sends checksum (optionally corrupted).
    task automatic load(input logic [5:0] l, input logic [7:0] base, input bit corrupt, input bit stall);
        logic [7:0]  sum;
        logic [7:0]  hb;
        logic [15:0] w;
        sum = 8'h00;
        for (int k = 0; k < int'(l); k++) begin
            hb = base + 8'(k);
            w  = {hb, ~hb};
            exp_q.push_back({5'(k), w});
            send(w[15:8], stall);
            send(w[7:0], stall);
            sum = sum + w[15:8] + w[7:0];
        end
        send(corrupt ? sum + 8'h01 : sum, stall);
    endtask

    task automatic check_result(input string tag, input bit run);
        check({tag, "_ce"},   {31'd0, cpu_ce},  {31'd0, run});
        check({tag, "_rst"},  {31'd0, cpu_rst}, {31'd0, !run});
        check({tag, "_done"}, {31'd0, done},    {31'd0, run});
        check({tag, "_err"},  {31'd0, err},     {31'd0, !run});
        check({tag, "_busy"}, {31'd0, busy},    32'd0);
    endtask

    typedef struct {
        logic [5:0] len;
        logic [7:0] base;
        bit         corrupt;
        bit         stall;
        bit         exp_run;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit saw_ready;

        vecs[0] = '{6'd1,  8'h00, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{6'd2,  8'h40, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{6'd5,  8'h7F, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{6'd32, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{6'd0,  8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{6'd33, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{6'd63, 8'h00, 1'b0, 1'b0, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        len    = 6'd0;
        valid  = 1'b0;
        byte_d = 8'h00;
        repeat (2) tick();
        check("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("reset_outs", {26'd0, cpu_ce, ready, pm_we, busy, done, err}, 32'd0);
        check("reset_pm", {11'd0, pm_addr, pm_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Reference stream: writes {0,1234},{1,ABCD}; checksum 0xBE.
        do_start(6'd2);
        exp_q.push_back({5'd0, 16'h1234});
        exp_q.push_back({5'd1, 16'hABCD});
        send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0); send(8'hBE, 0);
        check_result("good", 1'b1);
        tick();
        check("good_done_pulse", {31'd0, done}, 32'd0);
        check("good_ce_hold", {31'd0, cpu_ce}, 32'd1);

        do_start(6'd2);
        exp_q.push_back({5'd0, 16'h1234});
        exp_q.push_back({5'd1, 16'hABCD});
        send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0); send(8'h00, 0);
        check_result("badsum", 1'b0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].len != 6'd0 && vecs[i].len <= 6'd32) begin
                do_start(vecs[i].len);
                check($sformatf("v%0d_start_ready", i), {30'd0, ready, busy}, 32'd3);
                check($sformatf("v%0d_start_err", i), {31'd0, err}, 32'd0);
                load(vecs[i].len, vecs[i].base, vecs[i].corrupt, vecs[i].stall);
                check_result($sformatf("v%0d", i), vecs[i].exp_run);
                check($sformatf("v%0d_drained", i), exp_q.size(), 32'd0);
                if (vecs[i].len == 6'd32) begin
                    check("full_last_write", {11'd0, last_wr}, {11'd0, 5'd31, 16'h1FE0});
                end
            end else begin
                do_start(vecs[i].len);
                check($sformatf("v%0d_len_err", i), {29'd0, err, busy, cpu_rst}, 32'b101);
                saw_ready = ready;
                valid = 1'b1;
                byte_d = 8'h5A;
                repeat (5) begin
                    tick();
                    saw_ready |= ready;
                end
                valid = 1'b0;
                check($sformatf("v%0d_never_ready", i), {31'd0, saw_ready}, 32'd0);
            end
            tick();
        end

        // Abort after 3 bytes, with a byte offered alongside the restart.
        do_start(6'd4);
        exp_q.push_back({5'd0, 16'h0102});
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        start = 1'b1; len = 6'd1; valid = 1'b1; byte_d = 8'h04;
        tick();
        start = 1'b0; valid = 1'b0;
        exp_q.push_back({5'd0, 16'h5566});
        send(8'h55, 0); send(8'h66, 0); send(8'hBB, 0);
        check_result("reload", 1'b1);
        tick();

        // Restart from RUN takes the CPU back into reset on the next edge.
        do_start(6'd1);
        check("run_restart", {29'd0, cpu_rst, cpu_ce, busy}, 32'b101);

        // Reset pulse while waiting for the LO byte.
        send(8'h77, 0);
        #3 rst_n = 1'b0;
        #1;
        check("midlo_reset", {28'd0, busy, ready, pm_we, cpu_rst}, 32'b0001);
        #1 rst_n = 1'b1;
        valid = 1'b1; byte_d = 8'h88;
        repeat (3) tick();
        valid = 1'b0;
        check("midlo_idle", {30'd0, ready, busy}, 32'd0);

        // Asynchronous reset from RUN, asserted between clock edges.
        do_start(6'd1);
        exp_q.push_back({5'd0, 16'hA55A});
        send(8'hA5, 0); send(8'h5A, 0); send(8'hFF, 0);
        check("pre_async_ce", {31'd0, cpu_ce}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst", {30'd0, cpu_rst, cpu_ce}, 32'b10);
        check("async_outs", {27'd0, ready, pm_we, busy, done, err}, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of `cpu`. It receives a byte stream and assembles it into 16-bit instruction words, which it writes into the 32-entry program memory. It verifies an 8-bit additive checksum, then releases the CPU by deasserting the CPU's reset and asserting its clock enable. The CPU is held in reset whenever no verified program is loaded.

## Interface
Parameters:
- `ADDR_W`, default 5: program-memory address width (32 words); must match `cpu` PC width.
- `WORD_W`, default 16: instruction width; fixed at 2 bytes.

Ports:
- `i_clk`, in, 1: system clock; all state changes on rising edge.
- `i_rst_n`, in, 1: reset; asynchronous, active-low.
- `i_start`, in, 1: single-cycle request to begin a (re)load; samples `i_len`.
- `i_len`, in, 6: number of instruction words to load; legal range 1..32.
- `i_valid`, in, 1: `i_byte` holds a valid byte.
- `i_byte`, in, 8: stream byte.
- `o_ready`, out, 1: loader accepts a byte this cycle.
- `o_pm_we`, out, 1: program-memory write strobe, one cycle per word.
- `o_pm_addr`, out, `ADDR_W`: write address.
- `o_pm_data`, out, `WORD_W`: write data.
- `o_cpu_rst`, out, 1: drives `cpu` `i_rst` (active-high).
- `o_cpu_ce`, out, 1: drives `cpu` `i_ce`.
- `o_busy`, out, 1: load in progress.
- `o_done`, out, 1: one-cycle pulse on successful load.
- `o_err`, out, 1: level; load failed (bad length or checksum).

## Operation
- A byte is accepted only when `i_valid && o_ready`. There is no buffering; `i_byte` is ignored otherwise.
- FSM states (`ld_state_t`):
  - `LD_IDLE`
    - Waits for `i_start`.
  - `LD_HI`
    - Accepts the high byte of a word.
  - `LD_LO`
    - Accepts the low byte of a word.
  - `LD_CSUM`
    - Accepts the checksum byte.
  - `LD_RUN`
    - The CPU is released.
  - `LD_ERR`
    - Failure is latched.
- Transitions:
  - IDLE/RUN/ERR/any load state + `i_start`:
    - If `i_len` is in 1..32, go to `LD_HI`. Clear the word counter, checksum accumulator and `o_err`.
    - If `i_len` is 0 or greater than 32, go to `LD_ERR`.
  - HI + byte → LO, holding the high byte.
  - LO + byte → issue a write of `{hi, lo}` at address = word counter, then increment the counter.
    - If this was word `len-1`, go to CSUM; otherwise go to HI.
  - CSUM + byte:
    - If the byte equals the sum of all data bytes mod 256, go to RUN.
    - Otherwise go to ERR.
- The checksum accumulator is 8-bit and wraps on overflow. The checksum byte is not added to it.
- `i_start` has priority over a byte accepted in the same cycle: the load restarts and the byte is discarded.
- The word counter never wraps; the maximum address written is 31.
- Output levels by state:
  - `o_ready` = 1 in HI, LO and CSUM.
  - `o_busy` = 1 in HI, LO and CSUM.
  - `o_cpu_rst` = 1 in every state except RUN.
  - `o_cpu_ce` = 1 only in RUN.
  - `o_err` = 1 only in ERR.

## Timing
- Reset (asynchronous, immediate, including mid-load):
  - State goes to `LD_IDLE`.
  - `o_cpu_rst`=1.
  - `o_cpu_ce`=0, `o_ready`=0, `o_pm_we`=0, `o_busy`=0, `o_done`=0, `o_err`=0.
  - `o_pm_addr`=0, `o_pm_data`=0.
  - Partially written memory is not cleared.
- All outputs are registered.
- Write latency:
  - `o_pm_we`, `o_pm_addr` and `o_pm_data` are valid the cycle after the LO byte is accepted.
  - The write strobe is high for exactly one cycle.
- The next byte may be accepted in the cycle immediately after any acceptance.
- Fastest load of N words takes 2N+1 accepting cycles.
- On the cycle after a checksum match:
  - `o_cpu_rst` falls and `o_cpu_ce` rises together.
  - `o_done` pulses for 1 cycle.
  - The CPU fetches from address 0 from that edge onward.
- `i_start` while in RUN: `o_cpu_rst` reasserts and `o_cpu_ce` drops on the next edge.

## Structure
- `pkg`:
  - `ld_state_t` enum.
  - `PM_DEPTH` = 32.
  - `LD_MAX_LEN` = 32.
- Sub-module `ld_csum`: 8-bit wrapping accumulator with clear, add-enable and compare output.
- Everything else is one module: FSM, byte and word assembly, and the counter.

## Test plan
- Reset:
  - Assert `i_rst_n`=0 mid-cycle → outputs take their reset values without waiting for a clock edge; `o_cpu_rst`=1.
- Good load:
  - Stimulus: `i_start`, `i_len`=2, bytes 0x12, 0x34, 0xAB, 0xCD, checksum 0xBE.
  - Response: writes {0,0x1234} and {1,0xABCD}; `o_done` pulses once; `o_cpu_ce`=1 and `o_cpu_rst`=0 on the next cycle.
- Bad checksum:
  - Stimulus: same stream with checksum 0x00.
  - Response: `o_err`=1; `o_cpu_rst` stays 1; `o_cpu_ce`=0; no `o_done`.
- Full size with stalls:
  - Stimulus: `i_len`=32 with random `i_valid` gaps; word k = {k, ~k}.
  - Response: 32 writes, last at address 31 with data 0x1FE0; correct checksum accepted.
- Length errors:
  - `i_len`=0 → ERR next cycle, `o_ready` never asserted.
  - `i_len`=33 → same.
- Abort and reload:
  - `i_start` after 3 bytes → next write goes to address 0.
  - `i_start` while in RUN → `o_cpu_rst`=1 on the next cycle.
  - `i_rst_n` pulse during LO → IDLE with no pending write.
